// File: rtl/mul_pkg.sv
// Shared constants and types for the pipelined shift-add multiply-accumulate.
package mul_pkg;

    // Default operand width.
    localparam int MUL_N = 32;

    // Accumulator width for a given operand width: the full product plus an
    // N-bit addend always fits in 2N bits.
    function automatic int mul_acc_w(input int n);
        return 2 * n;
    endfunction

    localparam int MUL_ACC_W = mul_acc_w(MUL_N);

    // One pipeline slot at the default width. The pipeline declares an
    // equivalent record sized by its own N parameter.
    typedef struct packed {
        logic                 valid;
        logic [MUL_ACC_W-1:0] acc;
        logic [MUL_ACC_W-1:0] a;
        logic [MUL_N-1:0]     b;
    } mul_stage_rec_t;

endpackage

// File: rtl/mul_stage.sv
// One combinational shift-add step: adds (a << IDX) to the running
// accumulator when multiplier bit IDX is set.
import mul_pkg::*;

module mul_stage #(
    parameter int N   = MUL_N,
    parameter int IDX = 0
) (
    input  logic [2*N-1:0] acc_in,
    input  logic [2*N-1:0] a_in,
    input  logic           sel,
    output logic [2*N-1:0] acc_out
);

    // Conditional partial-product accumulation for this bit position.
    always_comb begin
        acc_out = acc_in;
        if (sel) begin
            acc_out = acc_in + (a_in << IDX);
        end
    end

endmodule

// File: rtl/mul_pipeline.sv
// Fully pipelined unsigned multiply-accumulate:
//   product = multiplicand * multiplier + addend, N+1 cycle latency.
// Optional macro MUL_PIPELINE_OVF_EN adds an ovf output flagging results
// that do not fit in N bits.
//
// Handshake: start marks the operands valid in the cycle it is sampled; there
// is no ready. Exactly one done pulse follows each accepted start after N+1
// clocks, in issue order, and the consumer must take product in that cycle.
import mul_pkg::*;

module mul_pipeline #(
    parameter int N = MUL_N
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    input  logic [N-1:0]     addend,
    input  logic             start,
    output logic [2*N-1:0]   product,
    output logic             done
`ifdef MUL_PIPELINE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int ACC_W = mul_acc_w(N);

    typedef struct packed {
        logic             valid;
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] a;
        logic [N-1:0]     b;
    } stage_t;

    // st[0] holds the captured operands; st[i+1] has multiplier bits 0..i
    // folded into acc.
    stage_t           st      [N+1];
    logic [ACC_W-1:0] acc_nxt [N];

    for (genvar i = 0; i < N; i++) begin : g_stage
        mul_stage #(
            .N   (N),
            .IDX (i)
        ) u_stage (
            .acc_in  (st[i].acc),
            .a_in    (st[i].a),
            .sel     (st[i].b[i]),
            .acc_out (acc_nxt[i])
        );
    end

    // Pipeline registers advance every clock; invalid slots carry don't-care data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= N; i++) begin
                st[i] <= '0;
            end
        end else begin
            st[0].valid <= start;
            st[0].acc   <= {{N{1'b0}}, addend};
            st[0].a     <= {{N{1'b0}}, multiplicand};
            st[0].b     <= multiplier;
            for (int i = 0; i < N; i++) begin
                st[i+1].valid <= st[i].valid;
                st[i+1].acc   <= acc_nxt[i];
                st[i+1].a     <= st[i].a;
                st[i+1].b     <= st[i].b;
            end
        end
    end

    // Output register: capture a finished result, otherwise hold the last one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
            done    <= 1'b0;
`ifdef MUL_PIPELINE_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= st[N].valid;
            if (st[N].valid) begin
                product <= st[N].acc;
`ifdef MUL_PIPELINE_OVF_EN
                ovf     <= |st[N].acc[ACC_W-1:N];
`endif
            end
        end
    end

endmodule

// File: tb/tb_mul_pipeline.sv
// Self-checking bench for mul_pipeline (N = 32, plus an N = 8 instance for
// the ovf output when MUL_PIPELINE_OVF_EN is defined).
`timescale 1ns/1ps

module tb_mul_pipeline;

    localparam int N = 32;
    localparam int W = 2 * N;

    // ---------------- clock / reset / DUT ----------------
    logic         clk          = 1'b0;
    logic         rst_n        = 1'b0;
    logic         start        = 1'b0;
    logic [N-1:0] multiplicand = '0;
    logic [N-1:0] multiplier   = '0;
    logic [N-1:0] addend       = '0;
    logic [W-1:0] product;
    logic         done;
`ifdef MUL_PIPELINE_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    mul_pipeline #(.N(N)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
        .start        (start),
        .product      (product),
        .done         (done)
`ifdef MUL_PIPELINE_OVF_EN
        ,
        .ovf          (ovf)
`endif
    );

`ifdef MUL_PIPELINE_OVF_EN
    logic [7:0]  a8 = '0, b8 = '0, c8 = '0;
    logic        start8 = 1'b0;
    logic [15:0] product8;
    logic        done8, ovf8;

    mul_pipeline #(.N(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .multiplicand (a8),
        .multiplier   (b8),
        .addend       (c8),
        .start        (start8),
        .product      (product8),
        .done         (done8),
        .ovf          (ovf8)
    );
`endif

    // ---------------- scoreboard ----------------
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    bit           finished = 1'b0;
    logic [W-1:0] exp_q[$];
    int           due_q[$];
    int           done_log[$];
    logic [W-1:0] last_prod = '0;
    logic         last_ovf  = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: each accepted start yields A*B+addend exactly N+1
    // edges later (edge index cyc+1 is the edge being processed here).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && start) begin
            exp_q.push_back(W'(multiplicand) * W'(multiplier) + W'(addend));
            due_q.push_back(cyc + 1 + N + 1);
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (!finished) begin
            if (!rst_n) begin
                exp_q.delete();
                due_q.delete();
                last_prod = '0;
                last_ovf  = 1'b0;
                check("rst_done", W'(done), '0);
                check("rst_product", product, '0);
            end else if (due_q.size() > 0 && due_q[0] == cyc) begin
                last_prod = exp_q.pop_front();
                void'(due_q.pop_front());
                last_ovf  = |last_prod[W-1:N];
                check("done_pulse", W'(done), W'(1));
                check("product", product, last_prod);
                done_log.push_back(cyc);
            end else begin
                check("done_idle", W'(done), '0);
                check("product_hold", product, last_prod);
                if (done) done_log.push_back(cyc);
            end
`ifdef MUL_PIPELINE_OVF_EN
            check("ovf", W'(ovf), W'(last_ovf));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
        multiplicand = a;
        multiplier   = b;
        addend       = c;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // Single op with hand-computed result: checks latency and value.
    task automatic single(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] c, input logic [W-1:0] exp);
        int base;
        int lat;
        base = cyc + 1;
        lat  = -1;
        issue(a, b, c);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - base;
                break;
            end
        end
        check({name, "_latency"}, W'(lat), W'(N + 1));
        check(name, product, exp);
        tick();
    endtask

    // ---------------- directed sequence ----------------
    logic [N-1:0] dq[64], dd[64], dr[64], dx[64];

    initial begin
        int base;

        // Reset held with start high.
        rst_n = 1'b0;
        issue(32'd1, 32'd1, 32'd1);
        multiplicand = 32'd3; multiplier = 32'd3; start = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("reset_product", product, '0);
        check("reset_done", W'(done), '0);
        #3;
        start = 1'b0;
        rst_n = 1'b1;
        done_log.delete();
        repeat (40) tick();
        check("no_start_no_done", W'(done_log.size()), '0);

        // Single op 7*6+5 = 47, exactly one pulse.
        done_log.delete();
        single("single_7x6p5", 32'd7, 32'd6, 32'd5, 64'd47);
        repeat (5) tick();
        check("single_pulse_count", W'(done_log.size()), W'(1));

        // Extremes and zero cases.
        single("extremes", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0000);
        single("zero_multiplicand", 32'd0, 32'd123, 32'd9, 64'd9);
        single("zero_multiplier", 32'd55, 32'd0, 32'd77, 64'd77);

        // Back-to-back divider reconstruction: dividend = q*d + r.
        for (int i = 0; i < 64; i++) begin
            dx[i] = $urandom();
            dd[i] = (i < 4) ? N'(i + 1) : $urandom_range(32'hFFFF_FFFF, 1);
            dq[i] = dx[i] / dd[i];
            dr[i] = dx[i] % dd[i];
        end
        fork
            begin
                for (int i = 0; i < 64; i++) issue(dd[i], dq[i], dr[i]);
            end
            begin
                int waited;
                waited = 0;
                @(negedge clk);
                while (!done && waited < 80) begin
                    @(negedge clk);
                    waited++;
                end
                for (int i = 0; i < 64; i++) begin
                    check("b2b_done", W'(done), W'(1));
                    check("b2b_dividend", product, W'(dx[i]));
                    @(negedge clk);
                end
                check("b2b_end_done", W'(done), '0);
            end
        join
        repeat (3) tick();

        // Bubbles: starts at relative cycles 0, 2, 3.
        done_log.delete();
        base = cyc + 1;
        issue(32'd10, 32'd3, 32'd1);
        tick();
        issue(32'd4, 32'd4, 32'd0);
        issue(32'd100, 32'd100, 32'd100);
        repeat (45) tick();
        check("bubble_count", W'(done_log.size()), W'(3));
        if (done_log.size() == 3) begin
            check("bubble_0", W'(done_log[0] - base), W'(33));
            check("bubble_1", W'(done_log[1] - base), W'(35));
            check("bubble_2", W'(done_log[2] - base), W'(36));
        end
        check("bubble_hold", product, 64'd10100);

        // Reset mid-flight: starts at 0..4, reset around cycle 10.
        done_log.delete();
        for (int i = 0; i < 5; i++) issue(N'(i + 2), 32'd9, 32'd1);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (45) tick();
        check("midflight_no_done", W'(done_log.size()), '0);
        @(negedge clk);
        check("midflight_product", product, '0);

`ifdef MUL_PIPELINE_OVF_EN
        // N = 8 overflow flag.
        for (int t = 0; t < 2; t++) begin
            int waited;
            a8 = (t == 0) ? 8'd16 : 8'd15;
            b8 = (t == 0) ? 8'd16 : 8'd17;
            c8 = 8'd0;
            start8 = 1'b1;
            tick();
            start8 = 1'b0;
            waited = 0;
            @(negedge clk);
            while (!done8 && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            check("ovf8_done", W'(done8), W'(1));
            check("ovf8_product", W'(product8), (t == 0) ? W'(256) : W'(255));
            check("ovf8_flag", W'(ovf8), (t == 0) ? W'(1) : W'(0));
            tick();
        end
`endif

        repeat (3) tick();
        check("model_drained", W'(exp_q.size()), '0);
        finished = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/mul_pipeline.md
Name: mul_pipeline

Overview:
- Fully pipelined unsigned shift-add multiply-accumulate: result = multiplicand * multiplier + addend.
- One operation accepted per clock; N+1 cycle latency.
- Inverse companion of the pipelined divider: quotient, divisor and remainder in; reconstructed dividend out.
- Sits beside the divider in the arithmetic datapath; also used by the divider bench as a self-check.

Parameters:
- N, 32, operand width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- multiplicand  input  N  unsigned operand A (divisor when reconstructing)
- multiplier  input  N  unsigned operand B (quotient when reconstructing)
- addend  input  N  unsigned value added to the product (remainder when reconstructing)
- start  input  1  operands valid this cycle
- product  output  2N  A*B + addend
- done  output  1  product valid, one-cycle pulse per accepted start

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid flags, accumulators and operand copies cleared;
  - product = 0, done = 0.
  - Reset release is synchronous to clk.
- Stage 0 registers every clock, regardless of start:
  - valid0 = start;
  - acc0 = {N'b0, addend};
  - a0 = {N'b0, multiplicand};
  - b0 = multiplier.
- Stage i+1, for i = 0..N-1, every clock:
  - acc(i+1) = acc(i) + (b(i)[i] ? a(i) << i : 0);
  - a, b and valid pass through unchanged.
  - Stages advance even when valid is 0; payload of invalid slots is don't-care.
- Width:
  - all accumulation is 2N bits wide;
  - the worst case (2^N-1)^2 + 2^N-1 = 2^2N - 2^N < 2^2N, so no carry is lost.
- Output register:
  - if valid(N) = 1: product = acc(N), done = 1;
  - otherwise done = 0 and product holds its last value.
- Latency: start sampled at edge k -> done = 1 and product valid after edge k+N+1.
- Throughput:
  - start may be high every cycle; back-to-back results emerge on consecutive cycles in issue order;
  - a gap in start gives a matching gap in done.
- No backpressure: the consumer must accept done when it is asserted.
- Reset mid-operation: all in-flight operations are discarded; no done is produced for them.
- Operand changes while start = 0 have no effect on any result.
- Zero cases:
  - multiplier = 0 -> product = addend;
  - multiplicand = 0 -> product = addend.

Optional Feature:
- Macro MUL_PIPELINE_OVF_EN.
- Defined:
  - adds output port ovf (1 bit), registered alongside product;
  - ovf = 1 when product[2N-1:N] != 0, i.e. the result does not fit N bits (invalid division reconstruction);
  - ovf resets to 0 and updates only when done = 1.
- Undefined: no ovf port and no extra logic.

Decomposition:
- Package mul_pkg:
  - default width constant MUL_N = 32;
  - localparam helper for accumulator width 2N;
  - stage record typedef {valid, acc[2N], a[2N], b[N]}.
- Sub-module mul_stage:
  - one combinational conditional shift-add step, parameterised by N and stage index;
  - instantiated N times by a generate loop.
- Registers stay in mul_pipeline.

Test Plan:
- Reset: hold rst_n low with start = 1 -> product = 0, done = 0; release, apply no start -> done stays 0.
- Single op, N=32: A = 7, B = 6, addend = 5, start for 1 cycle -> exactly one done pulse N+1 = 33 cycles later, product = 47.
- Extremes, N=32: A = B = addend = 0xFFFFFFFF -> product = 0xFFFFFFFF_00000000.
- Back-to-back plus divider check:
  - issue 64 random (q, d, r) triples from divider results on consecutive cycles;
  - expect done high for 64 consecutive cycles;
  - each product equals the original dividend, in issue order.
- Bubbles: starts at cycles 0, 2 and 3 -> done at cycles 33, 35 and 36 only; product holds between pulses.
- Mid-flight reset: start ops at cycles 0-4, assert rst_n low at cycle 10 -> no done ever for them; product = 0.
- MUL_PIPELINE_OVF_EN defined, N=8:
  - A = 16, B = 16, addend = 0 -> product = 256, ovf = 1;
  - A = 15, B = 17, addend = 0 -> product = 255, ovf = 0.
